// File: rtl/router_pkg.sv
// Shared router definitions: output direction indices and helpers that pull the
// signed dx/dy hop offsets out of a flit header.
package router_pkg;

  localparam int NUM_DIRS  = 5;
  localparam int DIR_LOCAL = 0;
  localparam int DIR_NORTH = 1;
  localparam int DIR_SOUTH = 2;
  localparam int DIR_EAST  = 3;
  localparam int DIR_WEST  = 4;

  // Extracts a two's-complement field of 'width' bits starting at bit 'lsb'.
  function automatic int signed signed_field(input logic [63:0] word,
                                             input int lsb,
                                             input int width);
    logic [63:0] f;
    f = (word >> lsb) & ((64'd1 << width) - 64'd1);
    if (f[width-1]) begin
      return int'(f) - (1 << width);
    end
    return int'(f);
  endfunction

  // dx occupies the top COORD_W bits of the flit.
  function automatic int signed get_dx(input logic [63:0] flit,
                                       input int flit_w,
                                       input int coord_w);
    return signed_field(flit, flit_w - coord_w, coord_w);
  endfunction

  // dy sits directly below dx.
  function automatic int signed get_dy(input logic [63:0] flit,
                                       input int flit_w,
                                       input int coord_w);
    return signed_field(flit, flit_w - 2 * coord_w, coord_w);
  endfunction

endpackage

// File: rtl/xy_route_port_if.sv
// Bundle of the router input port's upstream and downstream handshake signals.
interface xy_route_port_if
  import router_pkg::*;
#(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a sender holds valid and data stable until that edge, and
  // ready never depends combinationally on the partner's valid.
  logic [FLIT_W-1:0]   flit_in;
  logic                valid_in;
  logic                ready_in;
  logic [FLIT_W-1:0]   flit_out;
  logic [NUM_DIRS-1:0] valid_out;
  logic [NUM_DIRS-1:0] ready_out;
  logic [CNT_W-1:0]    occupancy;

  modport master (
    output flit_in, valid_in, ready_out,
    input  ready_in, flit_out, valid_out, occupancy
  );

  modport slave (
    input  flit_in, valid_in, ready_out,
    output ready_in, flit_out, valid_out, occupancy
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; head entry is readable combinationally.
module sync_fifo #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/xy_route_port.sv
// Buffered mesh-router input port with dimension-ordered (X then Y) routing.
// Define XY_HOP_UPDATE_EN to decrement the chosen offset on the outgoing flit.
module xy_route_port
  import router_pkg::*;
#(
  parameter int FLIT_W  = 16,
  parameter int COORD_W = 4,
  parameter int DEPTH   = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input logic              clk,
  input logic              rst_n,
  xy_route_port_if.slave   bus
);

  logic [FLIT_W-1:0]   head_flit;
  logic [CNT_W-1:0]    count;
  logic                empty;
  logic                push;
  logic                pop;
  int signed           dx;
  int signed           dy;
  logic [2:0]          dir_idx;
  logic [NUM_DIRS-1:0] route_onehot;
  logic [FLIT_W-1:0]   out_flit;

  // Acceptance looks only at the registered count, so ready_in never
  // combinationally depends on downstream ready_out.
  assign bus.ready_in  = (count < CNT_W'(DEPTH));
  assign bus.occupancy = count;
  assign push          = bus.valid_in && bus.ready_in;
  assign pop           = |(bus.valid_out & bus.ready_out);

  sync_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.flit_in),
    .pop       (pop),
    .head_data (head_flit),
    .count     (count),
    .empty     (empty)
  );

  assign dx = get_dx(64'(head_flit), FLIT_W, COORD_W);
  assign dy = get_dy(64'(head_flit), FLIT_W, COORD_W);

  // X is resolved fully before Y is considered.
  always_comb begin
    dir_idx = 3'(DIR_LOCAL);
    if (dx < 0) begin
      dir_idx = 3'(DIR_WEST);
    end else if (dx > 0) begin
      dir_idx = 3'(DIR_EAST);
    end else if (dy > 0) begin
      dir_idx = 3'(DIR_NORTH);
    end else if (dy < 0) begin
      dir_idx = 3'(DIR_SOUTH);
    end
    route_onehot          = '0;
    route_onehot[dir_idx] = 1'b1;
  end

`ifdef XY_HOP_UPDATE_EN
  logic [COORD_W-1:0] dx_field;
  logic [COORD_W-1:0] dy_field;

  assign dx_field = head_flit[FLIT_W-1 -: COORD_W];
  assign dy_field = head_flit[FLIT_W-COORD_W-1 -: COORD_W];

  // Only the presented copy is rewritten; the stored flit stays original.
  always_comb begin
    out_flit = head_flit;
    case (dir_idx)
      3'(DIR_EAST):  out_flit[FLIT_W-1 -: COORD_W]         = dx_field - COORD_W'(1);
      3'(DIR_WEST):  out_flit[FLIT_W-1 -: COORD_W]         = dx_field + COORD_W'(1);
      3'(DIR_NORTH): out_flit[FLIT_W-COORD_W-1 -: COORD_W] = dy_field - COORD_W'(1);
      3'(DIR_SOUTH): out_flit[FLIT_W-COORD_W-1 -: COORD_W] = dy_field + COORD_W'(1);
      default:       out_flit = head_flit;
    endcase
  end
`else
  assign out_flit = head_flit;
`endif

  assign bus.valid_out = empty ? '0 : route_onehot;
  assign bus.flit_out  = empty ? '0 : out_flit;

endmodule
